// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one 32-bit ALU between NREQ requesters. One request is granted per
//   cycle with round-robin priority. The result lands in a one-entry output
//   register and is returned over a valid/ready handshake, tagged with the
//   index of the requester that issued it.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_valid[NREQ]     per-requester operation valid
//   i_req_op_a/op_b       packed 32-bit operands, requester n at [32n+31:32n]
//   i_req_alu_op          packed 4-bit opcodes, requester n at [4n+3:4n]
//   o_req_ready[NREQ]     one-hot (or zero) accept strobe
//   o_rsp_valid/data/id   registered result, its value and source requester
//   i_rsp_ready           consumer takes the result this cycle
module alu_share_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [NREQ*32-1:0]   i_req_op_a,
  input  logic [NREQ*32-1:0]   i_req_op_b,
  input  logic [NREQ*4-1:0]    i_req_alu_op,
  output logic [NREQ-1:0]      o_req_ready,
  output logic                 o_rsp_valid,
  output logic [31:0]          o_rsp_data,
  output logic [IDW-1:0]       o_rsp_id,
  input  logic                 i_rsp_ready
);

  logic [IDW-1:0]    r_last_grant;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_data;
  logic [IDW-1:0]    r_rsp_id;

  logic [31:0]       w_op_a [NREQ];
  logic [31:0]       w_op_b [NREQ];
  logic [3:0]        w_op   [NREQ];

  logic              w_slot_free;
  logic              w_found;
  logic              w_grant;
  logic [IDW-1:0]    w_win;
  int                w_start;
  logic [2*NREQ-1:0] w_valid_dbl;
  logic [2*NREQ-1:0] w_rot;

  logic [31:0]       w_alu_a;
  logic [31:0]       w_alu_b;
  logic [3:0]        w_alu_op;
  logic [31:0]       w_alu_y;

  // Unpack the flat operand buses into per-requester arrays.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_op_a[gi] = i_req_op_a[32*gi +: 32];
      assign w_op_b[gi] = i_req_op_b[32*gi +: 32];
      assign w_op[gi]   = i_req_alu_op[4*gi +: 4];
    end
  endgenerate

  assign w_slot_free = !r_rsp_valid || i_rsp_ready;

  // Round-robin pick: rotate a doubled copy of the valid vector so that the
  // scan start sits at bit 0, then take the lowest set bit. A last_grant at
  // or beyond NREQ-1 (the latter only for non-power-of-2 NREQ) restarts at 0.
  assign w_valid_dbl = {i_req_valid, i_req_valid};

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    if (int'(r_last_grant) >= NREQ - 1) begin
      w_start = 0;
    end else begin
      w_start = int'(r_last_grant) + 1;
    end
    w_rot = w_valid_dbl >> w_start;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_win   = IDW'((w_start + k) % NREQ);
      end
    end
  end

  // Ready depends only on valids, slot state and reset, never on operands.
  assign w_grant     = w_found && w_slot_free && !i_rst;
  assign o_req_ready = w_grant ? (NREQ'(1) << w_win) : '0;

  // Operand mux; inputs held at zero when nothing is granted to avoid toggling.
  assign w_alu_a  = w_grant ? w_op_a[w_win] : 32'd0;
  assign w_alu_b  = w_grant ? w_op_b[w_win] : 32'd0;
  assign w_alu_op = w_grant ? w_op[w_win]   : 4'd0;

  // Shared ALU.
  always_comb begin
    w_alu_y = 32'd0;
    case (w_alu_op)
      4'd0:    w_alu_y = w_alu_a + w_alu_b;
      4'd1:    w_alu_y = w_alu_a - w_alu_b;
      4'd2:    w_alu_y = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
      4'd3:    w_alu_y = {31'd0, w_alu_a < w_alu_b};
      4'd4:    w_alu_y = w_alu_a ^ w_alu_b;
      4'd5:    w_alu_y = w_alu_a | w_alu_b;
      4'd6:    w_alu_y = w_alu_a & w_alu_b;
      4'd7:    w_alu_y = w_alu_a << w_alu_b[4:0];
      4'd8:    w_alu_y = w_alu_a >> w_alu_b[4:0];
      4'd9:    w_alu_y = $unsigned($signed(w_alu_a) >>> w_alu_b[4:0]);
      4'd10:   w_alu_y = w_alu_a;
      4'd11:   w_alu_y = w_alu_b;
      default: w_alu_y = 32'd0;
    endcase
  end

  // Output register: an accept overwrites (even while draining), a drain
  // without accept clears valid, otherwise everything holds.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= 32'd0;
      r_rsp_id     <= '0;
      r_last_grant <= IDW'(NREQ - 1);
    end else if (w_grant) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_data   <= w_alu_y;
      r_rsp_id     <= w_win;
      r_last_grant <= w_win;
    end else if (r_rsp_valid && i_rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Randomized and directed stimulus for alu_share_arbiter with a queue-based
//   scoreboard. The driver predicts grants from a plain reference model and
//   pushes expected results; an independent monitor pops on every consumed
//   response and checks held results during stalls.
module tb_alu_share_arbiter;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic [NREQ-1:0]     i_req_valid;
  logic [NREQ*32-1:0]  i_req_op_a;
  logic [NREQ*32-1:0]  i_req_op_b;
  logic [NREQ*4-1:0]   i_req_alu_op;
  logic [NREQ-1:0]     o_req_ready;
  logic                o_rsp_valid;
  logic [31:0]         o_rsp_data;
  logic [IDW-1:0]      o_rsp_id;
  logic                i_rsp_ready;

  alu_share_arbiter #(.NREQ(NREQ)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .i_req_op_a(i_req_op_a),
    .i_req_op_b(i_req_op_b), .i_req_alu_op(i_req_alu_op),
    .o_req_ready(o_req_ready),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .o_rsp_id(o_rsp_id), .i_rsp_ready(i_rsp_ready)
  );

  always #5 i_clk = ~i_clk;

  // Per-requester stimulus.
  bit          tv  [NREQ];
  logic [31:0] ta  [NREQ];
  logic [31:0] tbv [NREQ];
  logic [3:0]  top [NREQ];

  // Reference model state.
  int  m_last;
  bit  m_valid;
  logic [31:0] q_data[$];
  int          q_id[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [3:0] op);
    longint sa, sb;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    case (op)
      4'd0:  return 32'((longint'(a) + longint'(b)) % (64'd1 << 32));
      4'd1:  return 32'((longint'(a) - longint'(b) + (64'd1 << 32)) % (64'd1 << 32));
      4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd3:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      4'd4:  return a ^ b;
      4'd5:  return a | b;
      4'd6:  return a & b;
      4'd7:  return 32'((longint'(a) * (64'd1 << sh)) % (64'd1 << 32));
      4'd8:  return 32'(longint'(a) / (64'd1 << sh));
      4'd9:  return 32'(sa >>> sh);
      4'd10: return a;
      4'd11: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NREQ; i++) begin
      i_req_valid[i]          = tv[i];
      i_req_op_a[32*i +: 32]  = ta[i];
      i_req_op_b[32*i +: 32]  = tbv[i];
      i_req_alu_op[4*i +: 4]  = top[i];
    end
  endtask

  task automatic set_req(int n, bit v, logic [31:0] a, logic [31:0] b, logic [3:0] op);
    tv[n] = v; ta[n] = a; tbv[n] = b; top[n] = op;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  // One clock cycle: apply inputs, predict at the falling edge, then advance.
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    int w;
    pack();
    @(negedge i_clk);
    check("rsp_valid", 32'(o_rsp_valid), 32'(m_valid));
    exp_rdy = '0;
    if (i_rst) begin
      m_valid = 1'b0;
      m_last  = NREQ - 1;
      q_data.delete();
      q_id.delete();
    end else begin
      w = -1;
      if (!m_valid || i_rsp_ready) begin
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (m_last + 1 + k) % NREQ;
          if (w < 0 && tv[idx]) w = idx;
        end
      end
      if (w >= 0) begin
        exp_rdy[w] = 1'b1;
        q_data.push_back(ref_alu(ta[w], tbv[w], top[w]));
        q_id.push_back(w);
        m_last  = w;
        m_valid = 1'b1;
      end else if (m_valid && i_rsp_ready) begin
        m_valid = 1'b0;
      end
    end
    check("req_ready", 32'(o_req_ready), 32'(exp_rdy));
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: consumes responses and verifies stall stability.
  logic [31:0] h_data;
  logic [IDW-1:0] h_id;
  bit h_stall = 1'b0;
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        h_stall = 1'b0;
      end else begin
        if (h_stall) begin
          check("stall_data", o_rsp_data, h_data);
          check("stall_id", 32'(o_rsp_id), 32'(h_id));
        end
        if (o_rsp_valid && i_rsp_ready) begin
          if (q_data.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rsp_unexpected: got data 0x%08h id %0d, expected none", o_rsp_data, o_rsp_id);
          end else begin
            logic [31:0] ed;
            int eid;
            ed  = q_data.pop_front();
            eid = q_id.pop_front();
            check("rsp_data", o_rsp_data, ed);
            check("rsp_id", 32'(o_rsp_id), 32'(eid));
          end
        end
        h_stall = o_rsp_valid && !i_rsp_ready;
        h_data  = o_rsp_data;
        h_id    = o_rsp_id;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    m_last  = NREQ - 1;
    m_valid = 1'b0;
    i_rst   = 1'b1;
    i_rsp_ready = 1'b0;
    i_req_valid = '0; i_req_op_a = '0; i_req_op_b = '0; i_req_alu_op = '0;
    clear_reqs();
    #1;

    // Reset for two cycles, with a request present that must be ignored.
    set_req(0, 1'b1, 32'd7, 32'd7, 4'd0);
    step(); step();
    i_rst = 1'b0;
    check("reset_valid", 32'(o_rsp_valid), 32'd0);
    check("reset_data", o_rsp_data, 32'd0);
    check("reset_id", 32'(o_rsp_id), 32'd0);

    // Single request: 5 - 3.
    i_rsp_ready = 1'b1;
    set_req(0, 1'b1, 32'd5, 32'd3, 4'd1);
    pack(); #1;
    check("first_ready", 32'(o_req_ready), 32'd1);
    step();
    clear_reqs();
    pack(); #1;
    check("first_data", o_rsp_data, 32'd2);
    step();

    // Round-robin with wrap-around addition.
    set_req(0, 1'b1, 32'd1, 32'd1, 4'd0);
    set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'd0);
    repeat (6) step();

    // Backpressure while req1 waits.
    set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_req(1, 1'b1, 32'd100, 32'd23, 4'd1);
    i_rsp_ready = 1'b0;
    repeat (3) step();
    i_rsp_ready = 1'b1;
    step();
    clear_reqs();
    step();

    // Signed/unsigned compares, arithmetic shift, unused opcode.
    set_req(0, 1'b1, 32'h8000_0000, 32'd1, 4'd2); step();
    set_req(0, 1'b1, 32'h8000_0000, 32'd1, 4'd3); step();
    set_req(0, 1'b1, 32'h8000_0000, 32'd4, 4'd9); step();
    set_req(0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 4'd13); step();
    clear_reqs(); step();

    // Reset mid-operation with both requesters valid.
    set_req(0, 1'b1, 32'd9, 32'd1, 4'd0);
    i_rsp_ready = 1'b0;
    step();
    set_req(1, 1'b1, 32'd3, 32'd3, 4'd4);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    i_rsp_ready = 1'b1;
    pack(); #1;
    check("post_reset_ready", 32'(o_req_ready), 32'd1);
    step(); step();

    // Idle periods must not move priority.
    clear_reqs();
    set_req(0, 1'b1, 32'd4, 32'd4, 4'd5); step();
    clear_reqs();
    repeat (5) step();
    set_req(0, 1'b1, 32'd1, 32'd2, 4'd0);
    set_req(1, 1'b1, 32'd8, 32'd2, 4'd7);
    pack(); #1;
    check("idle_prio_ready", 32'(o_req_ready), 32'd2);
    step(); step();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      end
      i_rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Drain and confirm nothing is left outstanding.
    clear_reqs();
    i_rsp_ready = 1'b1;
    repeat (3) step();
    check("scoreboard_empty", 32'(q_data.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
